mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the execute stage's control/ALU outputs and `DataMemory`. Accepts one memory request at a time over a valid/ready handshake and drives `DataMemory`'s `Direccion`, `DataWr`, `DMWr` and `DMRd` ports. Sub-doubleword stores are performed as read-modify-write on the containing aligned doubleword. Load results are returned byte-lane-extracted and sign- or zero-extended. The core stalls on `req_ready` low.

## Interface
- `ADDR_W`, 64: address width; data path is fixed at 64 bits.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 doubleword.
- `req_unsigned`  in  1: load zero-extends when 1, sign-extends when 0; ignored for stores.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  64: store data, right-justified (lane 0 = LSB).
- `resp_valid`  out  1: one-cycle pulse; transaction finished.
- `resp_err`  out  1: valid with `resp_valid`; misaligned request.
- `resp_rdata`  out  64: extended load data, valid with `resp_valid`.
- `Direccion`  out  ADDR_W: memory address, always doubleword-aligned ({addr[ADDR_W-1:3],3'b000}).
- `DataWr`  out  64: memory write data.
- `DMWr`  out  1: memory write enable.
- `DMRd`  out  1: memory read enable.
- `Salida_LeSw`  in  64: memory read data.

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch all request fields.
    - Misaligned → RESP with err.
    - Aligned doubleword store → WR.
    - Any other aligned request → RD.
  - RD: `DMRd`=1, `Direccion` = aligned address. Next state CAP.
  - CAP: `DMRd`=1 held, `Direccion` held. Sample `Salida_LeSw` into a 64-bit buffer. Load → RESP; store → WR.
  - WR: `DMWr`=1, `DataWr` = merged doubleword, `Direccion` = aligned address. Next state RESP.
  - RESP: `resp_valid`=1 for exactly one cycle. Next state IDLE.
- Alignment rule: addr[0]=0 for half; addr[1:0]=0 for word; addr[2:0]=0 for doubleword. Bytes are always aligned.
- Lane select is little-endian: lane offset = addr[2:0]. Byte n occupies bits [8n+7:8n].
- Store merge: replace the size-wide field at the lane offset in the buffer with the low bits of `req_wdata`; all other bytes are preserved. A doubleword store writes `req_wdata` unmodified.
- Load extract: take the size-wide field at the lane offset and extend to 64 bits per `req_unsigned`. A doubleword load returns the buffer as-is.
- `resp_rdata` = 0 for stores and for errors. `resp_err`=1 only on misalignment.
- An errored request never asserts `DMRd` or `DMWr`.
- Outside their active states, `DMRd`=`DMWr`=0. `DataWr` and `Direccion` hold their last value.
- No response backpressure: the consumer must take `resp_valid` when it pulses.
- No new request is accepted until the unit has returned to IDLE, so the earliest back-to-back accept is the cycle after RESP.

## Timing
- Cycle 0 is the accept edge (IDLE with `req_valid`). `resp_valid` is high in:
  - cycle 1 for a misaligned request;
  - cycle 2 for a doubleword store;
  - cycle 3 for a load;
  - cycle 4 for a sub-doubleword store.
- `Salida_LeSw` is sampled at the end of CAP, one full cycle after `DMRd` rises. This holds for both a combinational-read and a one-cycle synchronous-read memory.
- All outputs are registered or decoded from state only; there is no combinational path from `req_*` to the memory ports.
- Reset values: state IDLE; `DMWr`=`DMRd`=0; `resp_valid`=`resp_err`=0; `resp_rdata`=0; `Direccion`=0; `DataWr`=0.
- `req_ready` is forced 0 while `rst`=1 and becomes 1 in the first cycle after release.
- Reset mid-operation: outputs clear immediately (asynchronous). A WR cycle cut by reset produces no memory write. No `resp_valid` is issued for the aborted request.

## Test plan
- Reset: assert `rst` for 2 cycles mid-idle → all outputs 0; `req_ready`=1 the cycle after release.
- Doubleword store, addr 0x3E0, wdata 0x1122334455667788 → WR with `Direccion`=0x3E0, `DMWr`=1, `DataWr`=0x1122334455667788; `resp_valid` in cycle 2 with `resp_err`=0.
- Byte store, addr 0x3E5, wdata 0xAB, memory at 0x3E0 = 0x1122334455667788 → `DMRd`=1 on 0x3E0 for 2 cycles, then `DataWr`=0x1122AB4455667788; `resp_valid` in cycle 4.
- Halfword load, addr 0x3E6, memory = 0x80FF000000000000 → `req_unsigned`=0 gives `resp_rdata`=0xFFFFFFFFFFFF80FF; `req_unsigned`=1 gives 0x00000000000080FF; `resp_valid` in cycle 3.
- Misaligned word load, addr 0x3E2 → `resp_valid`=1 and `resp_err`=1 in cycle 1; `DMRd`=`DMWr`=0 throughout.
- Sub-doubleword store with `rst` asserted during WR → `DMWr` drops the same cycle; memory word unchanged; no `resp_valid`; `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_req_if.sv
// Request/response channel between the execute stage and the load/store sequencer.
// The master side drives the request fields and consumes the one-cycle response pulse.
interface mem_req_if #(
  parameter int unsigned ADDR_W = 64
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [63:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of DataMemory: one request at a time, read-modify-write for
// sub-doubleword stores, lane extraction with sign/zero extension for loads.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_if.slave          req,
  output logic [ADDR_W-1:0] Direccion,
  output logic [63:0]       DataWr,
  output logic              DMWr,
  output logic              DMRd,
  input  logic [63:0]       Salida_LeSw
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;

  logic accept;
  logic misaligned;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    unique case (size)
      2'd0:    return 64'h0000_0000_0000_00ff;
      2'd1:    return 64'h0000_0000_0000_ffff;
      2'd2:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] dw, input logic [63:0] wd,
                                        input logic [1:0] size, input logic [2:0] off);
    logic [63:0] m;
    m = size_mask(size) << {off, 3'b000};
    return (dw & ~m) | ((wd << {off, 3'b000}) & m);
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] dw, input logic [1:0] size,
                                          input logic [2:0] off, input logic uns);
    logic [63:0] v;
    v = dw >> {off, 3'b000};
    unique case (size)
      2'd0:    return uns ? {56'd0, v[7:0]}  : {{56{v[7]}}, v[7:0]};
      2'd1:    return uns ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      2'd2:    return uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  assign accept = (state_q == StIdle) && req.req_valid;

  always_comb begin
    misaligned = 1'b0;
    unique case (req.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req.req_addr[0];
      2'd2:    misaligned = |req.req_addr[1:0];
      default: misaligned = |req.req_addr[2:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req.req_valid) begin
          if (misaligned)                                state_d = StResp;
          else if (req.req_we && req.req_size == 2'd3)   state_d = StWr;
          else                                           state_d = StRd;
        end
      end
      StRd:    state_d = StCap;
      StCap:   state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory strobes and handshake are pure state decodes, so reset kills them immediately.
  assign DMRd           = (state_q == StRd) || (state_q == StCap);
  assign DMWr           = (state_q == StWr);
  assign req.resp_valid = (state_q == StResp);
  assign req.req_ready  = (state_q == StIdle) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      size_q         <= 2'd0;
      unsigned_q     <= 1'b0;
      off_q          <= 3'd0;
      wdata_q        <= '0;
      Direccion      <= '0;
      DataWr         <= '0;
      req.resp_err   <= 1'b0;
      req.resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req.req_we;
        size_q     <= req.req_size;
        unsigned_q <= req.req_unsigned;
        off_q      <= req.req_addr[2:0];
        wdata_q    <= req.req_wdata;
        // Errored requests leave the memory-side registers untouched.
        if (!misaligned) Direccion <= {req.req_addr[ADDR_W-1:3], 3'b000};
        if (!misaligned && req.req_we && req.req_size == 2'd3) DataWr <= req.req_wdata;
      end
      if (state_q == StCap && we_q) DataWr <= merge(Salida_LeSw, wdata_q, size_q, off_q);
      // Response fields live for exactly the single RESP cycle.
      req.resp_err   <= accept && misaligned;
      req.resp_rdata <= (state_q == StCap && !we_q) ?
                        extract(Salida_LeSw, size_q, off_q, unsigned_q) : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized traffic against a byte-array
// reference model, and a reset-during-write sequence.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] Direccion, DataWr, Salida_LeSw;
  logic        DMWr, DMRd;

  int checks = 0;
  int errors = 0;

  mem_req_if #(.ADDR_W(64)) bus ();

  mem_access_unit #(.ADDR_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .Direccion  (Direccion),
    .DataWr     (DataWr),
    .DMWr       (DMWr),
    .DMRd       (DMRd),
    .Salida_LeSw(Salida_LeSw)
  );

  always #5 clk = ~clk;

  // Combinational-read memory of 128 doublewords; bench preloads go through the same port.
  logic [63:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_idx = '0;
  logic [63:0] pl_val = '0;

  always @(posedge clk) begin
    if (DMWr)       mem[Direccion[9:3]] <= DataWr;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end
  assign Salida_LeSw = mem[Direccion[9:3]];

  logic [7:0] ref_b [0:1023];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [6:0] idx, input logic [63:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err, output int lat,
                         output int n_rd, output int n_wr, output logic dir_bad,
                         output logic rdy_at_resp);
    rdata = '0; err = 1'b0; lat = 0; n_rd = 0; n_wr = 0; dir_bad = 1'b0; rdy_at_resp = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (DMRd) n_rd++;
      if (DMWr) n_wr++;
      if ((DMRd || DMWr) && Direccion !== {addr[63:3], 3'b000}) dir_bad = 1'b1;
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_rdata; err = bus.resp_err; rdy_at_resp = bus.req_ready;
      end
    end
  endtask

  // Expected strobe activity and latency straight from the transaction kind.
  task automatic chk_shape(input string tag, input logic we, input logic [1:0] size,
                           input logic err_exp, input int lat, input int n_rd, input int n_wr,
                           input logic dir_bad, input logic rdy);
    int lat_exp;
    lat_exp = err_exp ? 1 : (we ? (size == 2'd3 ? 2 : 4) : 3);
    chk({tag, ".lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, ".nrd"}, 64'(n_rd), (err_exp || (we && size == 2'd3)) ? 64'd0 : 64'd2);
    chk({tag, ".nwr"}, 64'(n_wr), (we && !err_exp) ? 64'd1 : 64'd0);
    chk({tag, ".dir"}, 64'(dir_bad), 64'd0);
    chk({tag, ".rdy"}, 64'(rdy), 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] pre;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [63:0] exp_mem;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [63:0] rdata, v, e;
    logic        err, dir_bad, rdy;
    int          lat, n_rd, n_wr, n, a;
    logic        we, uns;
    logic [1:0]  size;
    logic [63:0] addr, wdata;

    vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'h3e0, 64'h1122334455667788, 64'h0,
                 64'h0, 1'b0, 64'h1122334455667788};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 64'h3e5, 64'hffffffffffffffab, 64'h1122334455667788,
                 64'h0, 1'b0, 64'h1122ab4455667788};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 64'h3e6, 64'h0, 64'h80ff000000000000,
                 64'hffffffffffff80ff, 1'b0, 64'h80ff000000000000};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 64'h3e6, 64'h0, 64'h80ff000000000000,
                 64'h00000000000080ff, 1'b0, 64'h80ff000000000000};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 64'h3e2, 64'h0, 64'h5555,
                 64'h0, 1'b1, 64'h5555};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 64'h3e0, 64'h0, 64'h8000000000000001,
                 64'h8000000000000001, 1'b0, 64'h8000000000000001};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 64'h3e2, 64'hbeef, 64'h1122334455667788,
                 64'h0, 1'b0, 64'h11223344beef7788};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 64'h3e4, 64'hdeadbeef, 64'h1122334455667788,
                 64'h0, 1'b0, 64'hdeadbeef55667788};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 64'h3e7, 64'h0, 64'h8100000000000000,
                 64'hffffffffffffff81, 1'b0, 64'h8100000000000000};
    vecs[9]  = '{1'b0, 2'd2, 1'b1, 64'h3e4, 64'h0, 64'hf000000100000000,
                 64'h00000000f0000001, 1'b0, 64'hf000000100000000};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 64'h3e4, 64'h1234, 64'h7777,
                 64'h0, 1'b1, 64'h7777};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 64'h3e3, 64'h0, 64'h00000000ff000000,
                 64'h00000000000000ff, 1'b0, 64'h00000000ff000000};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(bus.req_ready), 64'd0);
    chk("rst.dmrd", 64'(DMRd), 64'd0);
    chk("rst.dmwr", 64'(DMWr), 64'd0);
    chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst.resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst.rdata", bus.resp_rdata, 64'd0);
    chk("rst.dir", Direccion, 64'd0);
    chk("rst.datawr", DataWr, 64'd0);
    rst = 1'b0;
    #1 chk("rst.ready_after", 64'(bus.req_ready), 64'd1);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      preload(7'h7c, vecs[i].pre);
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              rdata, err, lat, n_rd, n_wr, dir_bad, rdy);
      chk($sformatf("vec%0d.rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d.err", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d.mem", i), mem[7'h7c], vecs[i].exp_mem);
      chk_shape($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].exp_err,
                lat, n_rd, n_wr, dir_bad, rdy);
    end

    // Reset asserted during the WR cycle of a byte store: the write must not land.
    preload(7'h7c, 64'h1122334455667788);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'h3e5; bus.req_wdata = 64'hab;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstwr.dmwr_before", 64'(DMWr), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstwr.dmwr", 64'(DMWr), 64'd0);
    chk("rstwr.dmrd", 64'(DMRd), 64'd0);
    chk("rstwr.ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstwr.ready_after", 64'(bus.req_ready), 64'd1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) n++;
    end
    chk("rstwr.no_resp", 64'(n), 64'd0);
    chk("rstwr.mem", mem[7'h7c], 64'h1122334455667788);

    // Randomized traffic against a byte-addressed reference model.
    for (int i = 0; i < 128; i++) begin
      v = {$urandom, $urandom};
      preload(7'(i), v);
      for (int b = 0; b < 8; b++) ref_b[i*8 + b] = v[8*b +: 8];
    end
    for (int t = 0; t < 300; t++) begin
      we    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      a     = $urandom_range(0, 1023);
      addr  = {$urandom, 22'd0, 10'(a)};
      wdata = {$urandom, $urandom};
      n     = 1 << size;
      run_req(we, size, uns, addr, wdata, rdata, err, lat, n_rd, n_wr, dir_bad, rdy);
      e = '0;
      if ((a % n) == 0) begin
        if (we) begin
          for (int b = 0; b < n; b++) ref_b[a + b] = wdata[8*b +: 8];
        end else begin
          for (int b = 0; b < n; b++) e = e | (64'(ref_b[a + b]) << (8 * b));
          if (!uns && n < 8 && e[8*n-1]) e = e | ~((64'd1 << (8 * n)) - 64'd1);
        end
      end
      chk($sformatf("rnd%0d.err", t), 64'(err), 64'((a % n) != 0));
      chk($sformatf("rnd%0d.rdata", t), rdata, e);
      chk_shape($sformatf("rnd%0d", t), we, size, 1'((a % n) != 0),
                lat, n_rd, n_wr, dir_bad, rdy);
    end
    for (int i = 0; i < 128; i++) begin
      e = '0;
      for (int b = 0; b < 8; b++) e = e | (64'(ref_b[i*8 + b]) << (8 * b));
      chk($sformatf("rndmem%0d", i), mem[i], e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
